// File: rtl/sr_flag_arbiter_pkg.sv
// Shared definitions for the set/reset flag arbiter.
// - Op encodings carried on req_op.
// - Per-cell apply-stage state.
// - op_legal(): true for SET, RESET and TOGGLE.
package sr_flag_pkg;

    localparam logic [1:0] OP_ILL = 2'b00;
    localparam logic [1:0] OP_SET = 2'b01;
    localparam logic [1:0] OP_RST = 2'b10;
    localparam logic [1:0] OP_TGL = 2'b11;

    // Pending action for one flag cell, applied on the following edge
    typedef enum logic [1:0] {
        ST_HOLD = 2'b00,
        ST_SET  = 2'b01,
        ST_RST  = 2'b10
    } cell_st_e;

    function automatic logic op_legal(input logic [1:0] op);
        return op != OP_ILL;
    endfunction

endpackage

// File: rtl/sr_flag_arbiter_if.sv
// Requester-side bus of the flag arbiter.
// - req_valid : request pending, one bit per requester
// - req_op    : op per requester (SET / RESET / TOGGLE / illegal)
// - req_idx   : target flag index per requester
// - req_ready : grant, one-hot or zero
// master = requester side, slave = arbiter side.
interface sr_flag_arbiter_if #(
    parameter int NREQ    = 4,
    parameter int FLAG_AW = 3
);
    logic [NREQ-1:0]              req_valid;
    logic [NREQ-1:0][1:0]         req_op;
    logic [NREQ-1:0][FLAG_AW-1:0] req_idx;
    logic [NREQ-1:0]              req_ready;

    modport master (output req_valid, output req_op, output req_idx, input  req_ready);
    modport slave  (input  req_valid, input  req_op, input  req_idx, output req_ready);
endinterface

// File: rtl/sr_flag_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter.
// - req     : request vector
// - advance : grant enable; gnt is all zero when low
// - ptr     : highest-priority requester; search runs upward and wraps N-1 -> 0
// - gnt     : one-hot grant, or zero when nothing is requested
// The pointer register lives with the caller so the block can be reused.
module rr_arbiter #(
    parameter int N  = 4,
    parameter int PW = 2
) (
    input  logic [N-1:0]  req,
    input  logic          advance,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  gnt
);
    always_comb begin
        automatic int  j     = 0;
        automatic logic found = 1'b0;
        gnt = '0;
        for (int k = 0; k < N; k++) begin
            j = (int'(ptr) + k) % N;
            if (!found && advance && req[j]) begin
                gnt[j] = 1'b1;
                found  = 1'b1;
            end
        end
    end
endmodule

// File: rtl/sr_flag_arbiter.sv
// Shares a bank of NFLAG set/reset flag cells between NREQ requesters.
// Ports:
// - clk, rst : clock, synchronous active-low reset
// - bus      : requester bus (valid/op/idx in, ready out)
// - clr_all  : clear every flag on the next edge, discarding the staged op
// - flags    : registered flag-bank state
// - gnt_id   : id of the last granted requester
// - busy     : apply stage holds a valid op
// - err      : one-cycle pulse after an illegal op / out-of-range idx is applied
// A transfer at edge t is latched into the apply stage; the flag changes at t+1.
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter  int NREQ    = 4,
    parameter  int NFLAG   = 8,
    parameter  int FLAG_AW = 3,
    localparam int GW      = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst,
    sr_flag_arbiter_if.slave  bus,
    input  logic              clr_all,
    output logic [NFLAG-1:0]  flags,
    output logic [GW-1:0]     gnt_id,
    output logic              busy,
    output logic              err
);
    logic [GW-1:0]      ptr;
    logic [GW-1:0]      win;
    logic [NREQ-1:0]    gnt;
    logic               xfer;
    logic [1:0]         sel_op;
    logic [FLAG_AW-1:0] sel_idx;
    logic               sel_ill;
    logic               stg_ill;

    // Grants are suppressed while reset is asserted
    rr_arbiter #(.N(NREQ), .PW(GW)) u_arb (
        .req     (bus.req_valid),
        .advance (rst),
        .ptr     (ptr),
        .gnt     (gnt)
    );
    assign bus.req_ready = gnt;

    always_comb begin
        xfer    = |gnt;
        win     = '0;
        sel_op  = OP_ILL;
        sel_idx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt[i]) begin
                win     = GW'(i);
                sel_op  = bus.req_op[i];
                sel_idx = bus.req_idx[i];
            end
        end
        sel_ill = !op_legal(sel_op) || (int'(sel_idx) >= NFLAG);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            ptr     <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
            stg_ill <= 1'b0;
            err     <= 1'b0;
        end else begin
            busy    <= xfer;
            stg_ill <= xfer && sel_ill;
            // clr_all discards the staged op, including its error
            err     <= stg_ill && !clr_all;
            if (xfer) begin
                gnt_id <= win;
                ptr    <= (win == GW'(NREQ - 1)) ? '0 : win + GW'(1);
            end
        end
    end

    // Flag bank: each cell carries its own pending action (HOLD/SET/RST).
    // A TOGGLE is resolved into SET or RST when it is latched, using the
    // cell's next value so that a back-to-back op on the same index (or a
    // clr_all on that edge) is already accounted for.
    for (genvar j = 0; j < NFLAG; j++) begin : g_cell
        cell_st_e st, st_n;
        logic     q, q_n, s, r;

        always_comb begin
            s = 1'b0;
            r = 1'b0;
            case (st)
                ST_SET:  s = 1'b1;
                ST_RST:  r = 1'b1;
                default: ;
            endcase
            q_n  = clr_all ? 1'b0 : (s ? 1'b1 : (r ? 1'b0 : q));
            st_n = ST_HOLD;
            if (xfer && !sel_ill && int'(sel_idx) == j) begin
                case (sel_op)
                    OP_SET:  st_n = ST_SET;
                    OP_RST:  st_n = ST_RST;
                    OP_TGL:  st_n = q_n ? ST_RST : ST_SET;
                    default: st_n = ST_HOLD;
                endcase
            end
        end

        always_ff @(posedge clk) begin
            if (!rst) begin
                st <= ST_HOLD;
                q  <= 1'b0;
            end else begin
                st <= st_n;
                q  <= q_n;
            end
        end

        assign flags[j] = q;
    end

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// Randomized bench for sr_flag_arbiter. Two instances (NFLAG=8 and NFLAG=6)
// see identical requester traffic; a cycle-level model built from the
// request/grant/apply rules predicts grants, flags, busy, err and gnt_id.
module tb_sr_flag_arbiter;
    localparam int NREQ = 4;
    localparam int AW   = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr = 1'b0;
    always #5 clk = ~clk;

    logic [NREQ-1:0]         valid;
    logic [NREQ-1:0][1:0]    op;
    logic [NREQ-1:0][AW-1:0] idx;

    sr_flag_arbiter_if #(.NREQ(NREQ), .FLAG_AW(AW)) bi8 ();
    sr_flag_arbiter_if #(.NREQ(NREQ), .FLAG_AW(AW)) bi6 ();
    assign bi8.req_valid = valid;
    assign bi8.req_op    = op;
    assign bi8.req_idx   = idx;
    assign bi6.req_valid = valid;
    assign bi6.req_op    = op;
    assign bi6.req_idx   = idx;

    logic [7:0] flags8;
    logic [5:0] flags6;
    logic [1:0] gid8, gid6;
    logic       busy8, busy6, err8, err6;

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(8), .FLAG_AW(AW)) u8 (
        .clk(clk), .rst(rst), .bus(bi8), .clr_all(clr),
        .flags(flags8), .gnt_id(gid8), .busy(busy8), .err(err8));
    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(6), .FLAG_AW(AW)) u6 (
        .clk(clk), .rst(rst), .bus(bi6), .clr_all(clr),
        .flags(flags6), .gnt_id(gid6), .busy(busy6), .err(err6));

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference state
    int       m_ptr = 0;
    int       m_gid = 0;
    bit       m_bv  = 0;
    bit [1:0] m_op  = 0;
    int       m_idx = 0;
    bit [7:0] m_fl [2] = '{8'h00, 8'h00};
    bit       m_err[2] = '{1'b0, 1'b0};
    int       nfl  [2] = '{8, 6};

    function automatic int arb();
        if (!rst) return -1;
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (m_ptr + k) % NREQ;
            if (valid[j]) return j;
        end
        return -1;
    endfunction

    // One clock: check grant, take the edge, advance the model, check state.
    task automatic step(output int w);
        int rdy;
        w   = arb();
        rdy = (w < 0) ? 0 : (1 << w);
        #1;
        chk("ready8", bi8.req_ready, rdy);
        chk("ready6", bi6.req_ready, rdy);
        @(posedge clk);
        if (!rst) begin
            m_ptr = 0; m_gid = 0; m_bv = 0;
            m_fl  = '{8'h00, 8'h00};
            m_err = '{1'b0, 1'b0};
        end else begin
            for (int d = 0; d < 2; d++) begin
                m_err[d] = 1'b0;
                if (clr) m_fl[d] = '0;
                else if (m_bv) begin
                    if (m_op == 2'b00 || m_idx >= nfl[d]) m_err[d] = 1'b1;
                    else if (m_op == 2'b01) m_fl[d][m_idx] = 1'b1;
                    else if (m_op == 2'b10) m_fl[d][m_idx] = 1'b0;
                    else                    m_fl[d][m_idx] = ~m_fl[d][m_idx];
                end
            end
            m_bv = (w >= 0);
            if (w >= 0) begin
                m_op  = op[w];
                m_idx = int'(idx[w]);
                m_gid = w;
                m_ptr = (w + 1) % NREQ;
            end
        end
        #1;
        chk("flags8", flags8, m_fl[0]);
        chk("flags6", flags6, m_fl[1][5:0]);
        chk("busy8",  busy8,  m_bv);
        chk("busy6",  busy6,  m_bv);
        chk("err8",   err8,   m_err[0]);
        chk("err6",   err6,   m_err[1]);
        chk("gid8",   gid8,   m_gid);
        chk("gid6",   gid6,   m_gid);
    endtask

    initial begin
        int w;
        // Reset held for two edges with every requester asking
        rst   = 1'b0;
        valid = '1;
        for (int i = 0; i < NREQ; i++) begin
            op[i]  = 2'b01;
            idx[i] = AW'(i);
        end
        repeat (2) step(w);

        // Round-robin sweep: SET idx 0..3 held, grants 0,1,2,3 then refill
        rst = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step(w);
            if (w >= 0) valid[w] = 1'b0;
        end

        // Random traffic; requests hold op/idx until granted
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!valid[i] && $urandom_range(0, 2) == 0) begin
                    valid[i] = 1'b1;
                    op[i]    = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
                    idx[i]   = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 1))
                                                            : AW'($urandom_range(0, 7));
                end
            end
            clr = ($urandom_range(0, 11) == 0);
            rst = ($urandom_range(0, 59) != 0);
            step(w);
            if (w >= 0) valid[w] = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
